btb_update_queue: RTL

Write-side scheduler for the 4-way BTB. It accepts target-update requests from two requesters, EX (branch resolution) and ID (JAL/JALR decode), over valid/ready. Pending updates are buffered in a small in-order queue, and same-PC updates are coalesced. The queue drains at most one write per cycle into the BTB's single write port (load / write_address / in), and can be flushed on pipeline redirect.

---
 rtl/btb_update_queue_if.sv | 48 ++++
 rtl/btb_update_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/btb_update_queue_if.sv
// Request/drain bundle between the BTB update queue and its requesters / BTB write port.
// The slave modport is the queue itself; master is the surrounding pipeline side.
interface btb_update_queue_if #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 34
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               ex_req_valid;
  logic               ex_req_ready;
  logic [31:0]        ex_req_pc;
  logic [ENTRY_W-1:0] ex_req_entry;

  logic               id_req_valid;
  logic               id_req_ready;
  logic [31:0]        id_req_pc;
  logic [ENTRY_W-1:0] id_req_entry;

  logic               flush;
  logic               btb_hold;

  logic               btb_load;
  logic [31:0]        btb_write_address;
  logic [ENTRY_W-1:0] btb_in;

  logic [CW-1:0]      count;
  logic [15:0]        coalesce_cnt;

  modport slave (
    input  ex_req_valid, ex_req_pc, ex_req_entry,
    output ex_req_ready,
    input  id_req_valid, id_req_pc, id_req_entry,
    output id_req_ready,
    input  flush, btb_hold,
    output btb_load, btb_write_address, btb_in,
    output count, coalesce_cnt
  );

  modport master (
    output ex_req_valid, ex_req_pc, ex_req_entry,
    input  ex_req_ready,
    output id_req_valid, id_req_pc, id_req_entry,
    input  id_req_ready,
    output flush, btb_hold,
    input  btb_load, btb_write_address, btb_in,
    input  count, coalesce_cnt
  );
endinterface

// File: rtl/btb_update_queue.sv
// In-order BTB write queue: merges EX/ID target updates, coalesces same-PC entries,
// and drains one write per cycle into the BTB's single write port.
module btb_update_queue #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 34
) (
  input logic                 clk,
  input logic                 rst,
  btb_update_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]        pc_q  [DEPTH];
  logic [31:0]        pc_d  [DEPTH];
  logic [ENTRY_W-1:0] ent_q [DEPTH];
  logic [ENTRY_W-1:0] ent_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        coal_q, coal_d;

  logic               empty;
  logic [CW-1:0]      free;
  logic               ex_ready, id_ready;
  logic               ex_fire, id_fire;
  logic               pop;
  logic               ex_hit, id_hit;
  logic [PW-1:0]      ex_idx, id_idx;
  logic               same_pc;
  logic               ex_alloc, ex_merge;
  logic               id_alloc, id_merge;
  logic [PW-1:0]      id_slot;
  logic [1:0]         coal_inc;
  logic [16:0]        coal_sum;

  // Readiness is sized from the registered count only, so a request that would
  // coalesce can still stall while the queue is full.
  always_comb begin
    empty    = (count_q == '0);
    free     = CW'(DEPTH) - count_q;
    ex_ready = !rst && !bus.flush && (free != '0);
    id_ready = !rst && !bus.flush &&
               ((free >= CW'(2)) || ((free == CW'(1)) && !bus.ex_req_valid));
    pop      = !rst && !empty && !bus.btb_hold && !bus.flush;
    ex_fire  = bus.ex_req_valid && ex_ready;
    id_fire  = bus.id_req_valid && id_ready;
  end

  // PC match against live entries; a head that pops this cycle is not a target.
  always_comb begin
    ex_hit = 1'b0;
    ex_idx = '0;
    id_hit = 1'b0;
    id_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(pop && (PW'(i) == head_q))) begin
        if (pc_q[i] == bus.ex_req_pc) begin
          ex_hit = 1'b1;
          ex_idx = PW'(i);
        end
        if (pc_q[i] == bus.id_req_pc) begin
          id_hit = 1'b1;
          id_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    same_pc  = ex_fire && id_fire && (bus.ex_req_pc == bus.id_req_pc);
    ex_merge = ex_fire && ex_hit;
    ex_alloc = ex_fire && !ex_hit;
    id_merge = id_fire && !same_pc && id_hit;
    id_alloc = id_fire && !same_pc && !id_hit;
    id_slot  = tail_q + PW'(ex_alloc);
    // A same-cycle EX/ID pair on one PC counts as a single coalesce event.
    coal_inc = 2'(ex_merge) + 2'(id_merge) + 2'(same_pc && !ex_hit);
    coal_sum = {1'b0, coal_q} + 17'(coal_inc);
  end

  always_comb begin
    pc_d    = pc_q;
    ent_d   = ent_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(ex_alloc) + CW'(id_alloc) - CW'(pop);
    coal_d  = coal_sum[16] ? '1 : coal_sum[15:0];

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (ex_merge) begin
      ent_d[ex_idx] = bus.ex_req_entry;
    end
    if (ex_alloc) begin
      pc_d[tail_q]  = bus.ex_req_pc;
      ent_d[tail_q] = bus.ex_req_entry;
      vld_d[tail_q] = 1'b1;
    end
    if (id_merge) begin
      ent_d[id_idx] = bus.id_req_entry;
    end
    if (id_alloc) begin
      pc_d[id_slot]  = bus.id_req_pc;
      ent_d[id_slot] = bus.id_req_entry;
      vld_d[id_slot] = 1'b1;
    end
    tail_d = tail_q + PW'(ex_alloc) + PW'(id_alloc);

    if (bus.flush) begin
      vld_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ent_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      coal_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      coal_q  <= coal_d;
    end
  end

  assign bus.ex_req_ready      = ex_ready;
  assign bus.id_req_ready      = id_ready;
  assign bus.btb_load          = pop;
  assign bus.btb_write_address = empty ? '0 : pc_q[head_q];
  assign bus.btb_in            = empty ? '0 : ent_q[head_q];
  assign bus.count             = count_q;
  assign bus.coalesce_cnt      = coal_q;

endmodule
